// File: rtl/wb_dma_arbiter_pkg.sv
//==============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types for the two-master Wishbone DMA arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    typedef logic gnt_t;

    localparam gnt_t GNT_M0 = 1'b0;
    localparam gnt_t GNT_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wb_dma_arbiter_if.sv
//==============================================================================
// Module   : wb_dma_arbiter_if
// Purpose  : Pipelined Wishbone bus bundle with master/slave views.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface wb_dma_arbiter_if #(
    parameter int AW = 28,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic [SW-1:0] sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          stall;
    logic          ack;
    logic          err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, stall, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, stall, ack, err
    );

endinterface

`default_nettype wire

// File: rtl/wb_dma_arbiter.sv
//==============================================================================
// Module   : wb_dma_arbiter
// Purpose  : Round-robin 2:1 pipelined Wishbone arbiter with outstanding-strobe
//            limit and bus timeout that aborts a hung cycle with err.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_dma_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 28,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic         sys_clk,
    input  wire logic         rst,
    wb_dma_arbiter_if.slave   m0,
    wb_dma_arbiter_if.slave   m1,
    wb_dma_arbiter_if.master  s,
    output logic              timeout_o
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e     state_q, state_d;
    gnt_t           gnt_q, gnt_d;
    gnt_t           last_gnt_q, last_gnt_d;
    logic [CW-1:0]  out_cnt_q, out_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           abort_first_q, abort_first_d;

    logic           own_cyc;
    logic           own_stb;
    logic           own_we;
    logic [AW-1:0]  own_adr;
    logic [DW-1:0]  own_dat_w;
    logic [SW-1:0]  own_sel;
    logic           full;
    logic           accept;
    logic           resp;
    logic           to_clear;
    logic           g_stall;
    logic           g_ack;
    logic           g_err;

    assign own_cyc   = (gnt_q == GNT_M1) ? m1.cyc   : m0.cyc;
    assign own_stb   = (gnt_q == GNT_M1) ? m1.stb   : m0.stb;
    assign own_we    = (gnt_q == GNT_M1) ? m1.we    : m0.we;
    assign own_adr   = (gnt_q == GNT_M1) ? m1.adr   : m0.adr;
    assign own_dat_w = (gnt_q == GNT_M1) ? m1.dat_w : m0.dat_w;
    assign own_sel   = (gnt_q == GNT_M1) ? m1.sel   : m0.sel;

    assign full      = (out_cnt_q == CW'(MAX_OUT));

    assign s.adr     = own_adr;
    assign s.dat_w   = own_dat_w;
    assign s.sel     = own_sel;
    assign m0.dat_r  = s.dat_r;
    assign m1.dat_r  = s.dat_r;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_M0;
            last_gnt_q    <= GNT_M1;
            out_cnt_q     <= '0;
            to_cnt_q      <= '0;
            abort_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_gnt_q    <= last_gnt_d;
            out_cnt_q     <= out_cnt_d;
            to_cnt_q      <= to_cnt_d;
            abort_first_q <= abort_first_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_gnt_d    = last_gnt_q;
        out_cnt_d     = out_cnt_q;
        to_cnt_d      = to_cnt_q;
        abort_first_d = 1'b0;
        s.cyc         = 1'b0;
        s.stb         = 1'b0;
        s.we          = 1'b0;
        accept        = 1'b0;
        resp          = 1'b0;
        to_clear      = 1'b0;
        g_stall       = 1'b1;
        g_ack         = 1'b0;
        g_err         = 1'b0;
        timeout_o     = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0.cyc || m1.cyc) begin
                    state_d = OWN;
                    if (m0.cyc && m1.cyc) begin
                        gnt_d = ~last_gnt_q;
                    end else begin
                        gnt_d = gnt_t'(m1.cyc);
                    end
                end
            end

            OWN: begin
                s.cyc   = own_cyc;
                s.stb   = own_cyc & own_stb & ~full;
                s.we    = own_cyc & own_we;
                g_stall = s.stall | full;
                g_ack   = s.ack;
                g_err   = s.err;

                accept  = s.stb & ~s.stall;
                // A response with nothing outstanding is a slave fault; keep the count sane.
                resp    = (s.ack | s.err) && (out_cnt_q != '0);

                if (accept && !resp) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                end else if (resp && !accept) begin
                    out_cnt_d = out_cnt_q - CW'(1);
                end

                to_clear = accept | s.ack | s.err | (out_cnt_q == '0);
                to_cnt_d = to_clear ? '0 : to_cnt_q + TW'(1);

                if (!own_cyc) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                    out_cnt_d  = '0;
                    to_cnt_d   = '0;
                end else if (!to_clear && (to_cnt_q == TW'(TIMEOUT - 1))) begin
                    state_d       = ABORT;
                    abort_first_d = 1'b1;
                    out_cnt_d     = '0;
                    to_cnt_d      = '0;
                end
            end

            ABORT: begin
                g_err     = abort_first_q;
                timeout_o = abort_first_q;
                out_cnt_d = '0;
                to_cnt_d  = '0;
                if (!own_cyc) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Only the owner sees the slave; the loser is parked stalled and silent.
        m0.stall = 1'b1;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.stall = 1'b1;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        if (state_q != IDLE) begin
            if (gnt_q == GNT_M1) begin
                m1.stall = g_stall;
                m1.ack   = g_ack;
                m1.err   = g_err;
            end else begin
                m0.stall = g_stall;
                m0.ack   = g_ack;
                m0.err   = g_err;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_dma_arbiter.sv
//==============================================================================
// Module   : tb_wb_dma_arbiter
// Purpose  : Directed self-checking bench for wb_dma_arbiter (TIMEOUT=16).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_dma_arbiter;

    localparam int AW      = 28;
    localparam int DW      = 32;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 16;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    wb_dma_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
    wb_dma_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
    wb_dma_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

    wb_dma_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAX_OUT (MAX_OUT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .timeout_o (timeout_o)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_bus.adr = '0; m0_bus.dat_w = '0; m0_bus.sel = '0; m0_bus.we = 1'b0;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.sel = '0; m1_bus.we = 1'b0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        s_bus.dat_r = '0; s_bus.stall = 1'b0; s_bus.ack = 1'b0; s_bus.err = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        apply_reset();
        #1;
        n_tests++; if (s_bus.cyc !== 1'b0) begin n_fail++; $display("FAIL rst_s_cyc: got %b expected 0", s_bus.cyc); end
        n_tests++; if (s_bus.stb !== 1'b0) begin n_fail++; $display("FAIL rst_s_stb: got %b expected 0", s_bus.stb); end
        n_tests++; if (m0_bus.stall !== 1'b1) begin n_fail++; $display("FAIL rst_m0_stall: got %b expected 1", m0_bus.stall); end
        n_tests++; if (m1_bus.stall !== 1'b1) begin n_fail++; $display("FAIL rst_m1_stall: got %b expected 1", m1_bus.stall); end
        n_tests++; if ({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err} !== 4'b0) begin n_fail++; $display("FAIL rst_ack_err: got %b expected 0000", {m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}); end
        n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", timeout_o); end
    endtask

    task automatic test_single_read();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 28'h0001234; m0_bus.sel = 4'hF; m0_bus.we = 1'b0;
        #1;
        n_tests++; if (s_bus.cyc !== 1'b0) begin n_fail++; $display("FAIL rd_arb_latency: got s_cyc=%b expected 0", s_bus.cyc); end
        step();
        n_tests++; if (s_bus.cyc !== 1'b1 || s_bus.stb !== 1'b1) begin n_fail++; $display("FAIL rd_s_cyc_stb: got %b%b expected 11", s_bus.cyc, s_bus.stb); end
        n_tests++; if (s_bus.adr !== 28'h0001234) begin n_fail++; $display("FAIL rd_s_adr: got %h expected 0001234", s_bus.adr); end
        n_tests++; if (s_bus.sel !== 4'hF || s_bus.we !== 1'b0) begin n_fail++; $display("FAIL rd_s_sel_we: got %h/%b expected f/0", s_bus.sel, s_bus.we); end
        n_tests++; if (m0_bus.stall !== 1'b0) begin n_fail++; $display("FAIL rd_m0_stall: got %b expected 0", m0_bus.stall); end
        step();
        m0_bus.stb = 1'b0;
        #1;
        n_tests++; if (m0_bus.ack !== 1'b0 || m1_bus.stall !== 1'b1) begin n_fail++; $display("FAIL rd_wait: got ack=%b m1_stall=%b expected 0/1", m0_bus.ack, m1_bus.stall); end
        step();
        s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEADBEEF;
        #1;
        n_tests++; if (m0_bus.ack !== 1'b1) begin n_fail++; $display("FAIL rd_m0_ack: got %b expected 1", m0_bus.ack); end
        n_tests++; if (m0_bus.dat_r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_m0_dat_r: got %h expected deadbeef", m0_bus.dat_r); end
        n_tests++; if (m1_bus.stall !== 1'b1 || m1_bus.ack !== 1'b0) begin n_fail++; $display("FAIL rd_m1_loser: got stall=%b ack=%b expected 1/0", m1_bus.stall, m1_bus.ack); end
        step();
        s_bus.ack = 1'b0;
        #1;
        n_tests++; if (m0_bus.ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse: got %b expected 0", m0_bus.ack); end
        m0_bus.cyc = 1'b0;
        #1;
        n_tests++; if (s_bus.cyc !== 1'b0) begin n_fail++; $display("FAIL rd_cyc_follow: got %b expected 0", s_bus.cyc); end
        step();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1;
            step();
            if ((i % 2) == 0) begin
                n_tests++; if (m0_bus.stall !== 1'b0 || m1_bus.stall !== 1'b1) begin n_fail++; $display("FAIL rr_iter%0d: got m0_stall=%b m1_stall=%b expected 0/1", i, m0_bus.stall, m1_bus.stall); end
            end else begin
                n_tests++; if (m1_bus.stall !== 1'b0 || m0_bus.stall !== 1'b1) begin n_fail++; $display("FAIL rr_iter%0d: got m0_stall=%b m1_stall=%b expected 1/0", i, m0_bus.stall, m1_bus.stall); end
            end
            m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
            step();
        end
    endtask

    task automatic test_outstanding();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 28'h0000040;
        step();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (m1_bus.stall !== 1'b0 || s_bus.stb !== 1'b1) begin n_fail++; $display("FAIL out_accept%0d: got stall=%b s_stb=%b expected 0/1", i, m1_bus.stall, s_bus.stb); end
            step();
        end
        n_tests++; if (m1_bus.stall !== 1'b1 || s_bus.stb !== 1'b0) begin n_fail++; $display("FAIL out_full: got stall=%b s_stb=%b expected 1/0", m1_bus.stall, s_bus.stb); end
        step();
        for (int i = 0; i < 2; i++) begin
            s_bus.ack = 1'b1;
            #1;
            n_tests++; if (m1_bus.ack !== 1'b1 || m1_bus.stall !== 1'b1) begin n_fail++; $display("FAIL out_ack%0d: got ack=%b stall=%b expected 1/1", i, m1_bus.ack, m1_bus.stall); end
            step();
            s_bus.ack = 1'b0;
            #1;
            n_tests++; if (m1_bus.stall !== 1'b0) begin n_fail++; $display("FAIL out_release%0d: got stall=%b expected 0", i, m1_bus.stall); end
            step();
        end
        m1_bus.stb = 1'b0;
        #1;
        n_tests++; if (m1_bus.stall !== 1'b1) begin n_fail++; $display("FAIL out_refull: got stall=%b expected 1", m1_bus.stall); end
        s_bus.ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        s_bus.ack = 1'b0;
        m1_bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_simul_stb_ack();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        step();
        step();
        step();
        s_bus.ack = 1'b1;
        #1;
        n_tests++; if (m0_bus.stall !== 1'b0 || m0_bus.ack !== 1'b1) begin n_fail++; $display("FAIL sim_both: got stall=%b ack=%b expected 0/1", m0_bus.stall, m0_bus.ack); end
        step();
        s_bus.ack = 1'b0;
        #1;
        n_tests++; if (m0_bus.stall !== 1'b0) begin n_fail++; $display("FAIL sim_third: got stall=%b expected 0", m0_bus.stall); end
        step();
        n_tests++; if (m0_bus.stall !== 1'b0) begin n_fail++; $display("FAIL sim_fourth: got stall=%b expected 0", m0_bus.stall); end
        step();
        n_tests++; if (m0_bus.stall !== 1'b1) begin n_fail++; $display("FAIL sim_full: got stall=%b expected 1", m0_bus.stall); end
        m0_bus.stb = 1'b0;
        s_bus.ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        s_bus.ack = 1'b0;
        m0_bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        step();
        m1_bus.cyc = 1'b1;
        #1;
        n_tests++; if (m0_bus.stall !== 1'b0) begin n_fail++; $display("FAIL to_accept: got stall=%b expected 0", m0_bus.stall); end
        step();
        m0_bus.stb = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            n_tests++; if (s_bus.cyc !== 1'b1 || m0_bus.err !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got cyc=%b err=%b to=%b expected 1/0/0", i, s_bus.cyc, m0_bus.err, timeout_o); end
            step();
        end
        n_tests++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin n_fail++; $display("FAIL to_abort_cyc: got %b%b expected 00", s_bus.cyc, s_bus.stb); end
        n_tests++; if (m0_bus.err !== 1'b1 || timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_abort_err: got err=%b to=%b expected 1/1", m0_bus.err, timeout_o); end
        n_tests++; if (m0_bus.stall !== 1'b1 || m1_bus.err !== 1'b0) begin n_fail++; $display("FAIL to_abort_stall: got stall=%b m1_err=%b expected 1/0", m0_bus.stall, m1_bus.err); end
        step();
        s_bus.ack = 1'b1;
        #1;
        n_tests++; if (m0_bus.err !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got err=%b to=%b expected 0/0", m0_bus.err, timeout_o); end
        n_tests++; if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin n_fail++; $display("FAIL to_late_ack: got m0=%b m1=%b expected 0/0", m0_bus.ack, m1_bus.ack); end
        step();
        s_bus.ack = 1'b0;
        m0_bus.cyc = 1'b0;
        step();
        step();
        n_tests++; if (m1_bus.stall !== 1'b0 || s_bus.cyc !== 1'b1) begin n_fail++; $display("FAIL to_m1_grant: got stall=%b s_cyc=%b expected 0/1", m1_bus.stall, s_bus.cyc); end
        m1_bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_cycle();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        m1_bus.stb = 1'b0;
        rst = 1'b1;
        step();
        s_bus.ack = 1'b1;
        #1;
        n_tests++; if (s_bus.cyc !== 1'b0) begin n_fail++; $display("FAIL mid_s_cyc: got %b expected 0", s_bus.cyc); end
        n_tests++; if (m1_bus.ack !== 1'b0) begin n_fail++; $display("FAIL mid_no_ack: got %b expected 0", m1_bus.ack); end
        rst = 1'b0;
        s_bus.ack = 1'b0;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        step();
        n_tests++; if (m0_bus.stall !== 1'b0 || m1_bus.stall !== 1'b1) begin n_fail++; $display("FAIL mid_first_grant: got m0_stall=%b m1_stall=%b expected 0/1", m0_bus.stall, m1_bus.stall); end
        for (int i = 0; i < 3; i++) step();
        n_tests++; if (m0_bus.stall !== 1'b0) begin n_fail++; $display("FAIL mid_cnt_cleared: got stall=%b expected 0", m0_bus.stall); end
        step();
        n_tests++; if (m0_bus.stall !== 1'b1) begin n_fail++; $display("FAIL mid_full: got stall=%b expected 1", m0_bus.stall); end
        drive_idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_outstanding();
        test_simul_stb_ack();
        test_timeout();
        test_reset_mid_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
